// File: rtl/fir_equalizer.sv
// Adaptive FIR equalizer datapath: 2-PAM slicer plus error, aligned sample and LMS enable for the coefficient updater.
// Latency: one cycle from an i_valid sample to o_valid with registered results.
// Backpressure: none; every accepted sample yields one output, and i_flush drops the sample in flight.
module fir_equalizer #(
    parameter int DATA_BW = 9,
    parameter int COEF_BW = 9,
    parameter int N_COEF  = 7,
    parameter int ERR_BW  = 8,
    parameter int WARMUP  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [DATA_BW-1:0]         i_data,
    input  logic                       i_valid,
    input  logic                       i_flush,
    input  logic [COEF_BW*N_COEF-1:0]  i_coefs,
    input  logic                       i_coef_load,
    output logic [DATA_BW-1:0]         o_y,
    output logic                       o_dec,
    output logic [ERR_BW-1:0]          o_err,
    output logic [DATA_BW-1:0]         o_x,
    output logic                       o_valid,
    output logic                       o_lms_en
);

    localparam int C       = N_COEF / 2;
    localparam int FRAC    = 7;
    localparam int PROD_BW = DATA_BW + COEF_BW;
    localparam int ACC_BW  = PROD_BW + $clog2(N_COEF);
    localparam int YF_BW   = ACC_BW - FRAC;
    localparam int E_BW    = DATA_BW + 1;
    localparam int CNT_MAX = (WARMUP > N_COEF) ? WARMUP : N_COEF;
    localparam int CNT_BW  = $clog2(CNT_MAX + 1);

    localparam logic signed [COEF_BW-1:0] COEF_ONE = COEF_BW'(1 << FRAC);
    localparam logic signed [YF_BW-1:0]   Y_MAX    = YF_BW'((1 << (DATA_BW - 1)) - 1);
    localparam logic signed [YF_BW-1:0]   Y_MIN    = YF_BW'(-(1 << (DATA_BW - 1)));
    localparam logic signed [E_BW-1:0]    E_MAX    = E_BW'((1 << (ERR_BW - 1)) - 1);
    localparam logic signed [E_BW-1:0]    E_MIN    = E_BW'(-(1 << (ERR_BW - 1)));
    localparam logic signed [E_BW-1:0]    D_POS    = E_BW'(1 << FRAC);
    localparam logic signed [E_BW-1:0]    D_NEG    = E_BW'(-(1 << FRAC));

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    logic signed [DATA_BW-1:0] dly      [N_COEF-1];
    logic signed [DATA_BW-1:0] x_tap    [N_COEF];
    logic signed [COEF_BW-1:0] coef_in  [N_COEF];
    logic signed [COEF_BW-1:0] active   [N_COEF];
    logic signed [COEF_BW-1:0] shadow   [N_COEF];
    logic signed [COEF_BW-1:0] coef_use [N_COEF];
    logic signed [PROD_BW-1:0] prod     [N_COEF];
    logic                      pending;

    logic signed [ACC_BW-1:0]  acc;
    logic signed [YF_BW-1:0]   y_full;
    logic signed [DATA_BW-1:0] y_sat;
    logic                      dec;
    logic signed [E_BW-1:0]    d_val;
    logic signed [E_BW-1:0]    e_full;
    logic signed [ERR_BW-1:0]  e_sat;

    state_t                    state;
    state_t                    state_n;
    logic [CNT_BW-1:0]         cnt;
    logic [CNT_BW-1:0]         cnt_n;
    logic [CNT_BW-1:0]         cnt_inc;

    logic                      take;
    logic                      xfer;

    // Flush wins over a coincident sample; a pending bank moves in only with an accepted sample.
    assign take = i_valid & ~i_flush;
    assign xfer = take & pending;

    always_comb begin
        x_tap[0] = i_data;
        for (int k = 1; k < N_COEF; k++) begin
            x_tap[k] = dly[k-1];
        end
    end

    // The sample that performs the transfer already sees the shadow bank.
    always_comb begin
        for (int k = 0; k < N_COEF; k++) begin
            coef_in[k]  = i_coefs[COEF_BW*k +: COEF_BW];
            coef_use[k] = pending ? shadow[k] : active[k];
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < N_COEF; k++) begin
            prod[k] = x_tap[k] * coef_use[k];
            acc     = acc + ACC_BW'(prod[k]);
        end
    end

    always_comb begin
        y_full = acc[ACC_BW-1:FRAC];
        if (y_full > Y_MAX) begin
            y_sat = Y_MAX[DATA_BW-1:0];
        end else if (y_full < Y_MIN) begin
            y_sat = Y_MIN[DATA_BW-1:0];
        end else begin
            y_sat = y_full[DATA_BW-1:0];
        end
    end

    always_comb begin
        dec    = ~y_sat[DATA_BW-1];
        d_val  = dec ? D_POS : D_NEG;
        e_full = d_val - E_BW'(y_sat);
        if (e_full > E_MAX) begin
            e_sat = E_MAX[ERR_BW-1:0];
        end else if (e_full < E_MIN) begin
            e_sat = E_MIN[ERR_BW-1:0];
        end else begin
            e_sat = e_full[ERR_BW-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_COEF - 1; k++) begin
                dly[k] <= '0;
            end
        end else if (i_flush) begin
            for (int k = 0; k < N_COEF - 1; k++) begin
                dly[k] <= '0;
            end
        end else if (i_valid) begin
            dly[0] <= i_data;
            for (int k = 1; k < N_COEF - 1; k++) begin
                dly[k] <= dly[k-1];
            end
        end
    end

    // A load in the same cycle as a transfer refills the shadow and keeps pending set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_COEF; k++) begin
                active[k] <= (k == C) ? COEF_ONE : '0;
                shadow[k] <= (k == C) ? COEF_ONE : '0;
            end
            pending <= 1'b0;
        end else begin
            if (xfer) begin
                for (int k = 0; k < N_COEF; k++) begin
                    active[k] <= shadow[k];
                end
            end
            if (i_coef_load) begin
                for (int k = 0; k < N_COEF; k++) begin
                    shadow[k] <= coef_in[k];
                end
                pending <= 1'b1;
            end else if (xfer) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_FILL;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cnt_inc = cnt + CNT_BW'(1);
        if (i_flush) begin
            state_n = S_FILL;
            cnt_n   = '0;
        end else if (i_valid) begin
            case (state)
                S_FILL: begin
                    if (cnt_inc == CNT_BW'(N_COEF - 1)) begin
                        state_n = S_WARM;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                S_WARM: begin
                    if (cnt_inc == CNT_BW'(WARMUP)) begin
                        state_n = S_RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                S_RUN: begin
                    state_n = S_RUN;
                end
                default: begin
                    state_n = S_FILL;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_y      <= '0;
            o_dec    <= 1'b1;
            o_err    <= '0;
            o_x      <= '0;
            o_valid  <= 1'b0;
            o_lms_en <= 1'b0;
        end else begin
            o_valid  <= take;
            o_lms_en <= take & (state == S_RUN);
            if (take) begin
                o_y   <= y_sat;
                o_dec <= dec;
                o_err <= e_sat;
                o_x   <= i_data;
            end
        end
    end

endmodule

// File: tb/tb_fir_equalizer.sv
// Bench for fir_equalizer: directed and random samples scored against a tap-history reference model.
module tb_fir_equalizer;

    localparam int DATA_BW = 9;
    localparam int COEF_BW = 9;
    localparam int N_COEF  = 7;
    localparam int ERR_BW  = 8;
    localparam int WARMUP  = 16;
    localparam int CB      = COEF_BW * N_COEF;
    localparam int LMS_AT  = N_COEF - 1 + WARMUP + 1;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic [DATA_BW-1:0] i_data = '0;
    logic               i_valid = 1'b0;
    logic               i_flush = 1'b0;
    logic [CB-1:0]      i_coefs = '0;
    logic               i_coef_load = 1'b0;
    logic [DATA_BW-1:0] o_y;
    logic               o_dec;
    logic [ERR_BW-1:0]  o_err;
    logic [DATA_BW-1:0] o_x;
    logic               o_valid;
    logic               o_lms_en;

    fir_equalizer #(
        .DATA_BW(DATA_BW), .COEF_BW(COEF_BW), .N_COEF(N_COEF),
        .ERR_BW(ERR_BW), .WARMUP(WARMUP)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
        .i_flush(i_flush), .i_coefs(i_coefs), .i_coef_load(i_coef_load),
        .o_y(o_y), .o_dec(o_dec), .o_err(o_err), .o_x(o_x),
        .o_valid(o_valid), .o_lms_en(o_lms_en)
    );

    always #5 i_clk = ~i_clk;

    int tests  = 0;
    int failed = 0;

    // Reference model: tap history, both banks as integers, valid-sample count since reset/flush.
    int                 m_act  [N_COEF];
    int                 m_sh   [N_COEF];
    int                 m_hist [N_COEF-1];
    bit                 m_pend;
    int                 m_nv;
    logic [DATA_BW-1:0] e_y;
    logic               e_dec;
    logic [ERR_BW-1:0]  e_err;
    logic [DATA_BW-1:0] e_x;
    logic               e_vld;
    logic               e_lms;

    function automatic int sat(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic [CB-1:0] all_taps(input logic [COEF_BW-1:0] v);
        return {N_COEF{v}};
    endfunction

    function automatic logic [CB-1:0] centre_tap(input logic [COEF_BW-1:0] v);
        logic [CB-1:0] r;
        r = '0;
        r[COEF_BW*(N_COEF/2) +: COEF_BW] = v;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_COEF; k++) begin
            m_act[k] = (k == N_COEF/2) ? 128 : 0;
            m_sh[k]  = m_act[k];
        end
        for (int k = 0; k < N_COEF-1; k++) m_hist[k] = 0;
        m_pend = 0;
        m_nv   = 0;
        e_y = '0; e_dec = 1'b1; e_err = '0; e_x = '0; e_vld = 1'b0; e_lms = 1'b0;
    endtask

    task automatic model_step();
        int win  [N_COEF];
        int bank [N_COEF];
        int acc, y, d;
        if (i_flush) begin
            for (int k = 0; k < N_COEF-1; k++) m_hist[k] = 0;
            m_nv  = 0;
            e_vld = 1'b0;
            e_lms = 1'b0;
        end else if (i_valid) begin
            for (int k = 0; k < N_COEF; k++) bank[k] = m_pend ? m_sh[k] : m_act[k];
            if (m_pend) begin
                for (int k = 0; k < N_COEF; k++) m_act[k] = m_sh[k];
                m_pend = 0;
            end
            win[0] = $signed(i_data);
            for (int k = 1; k < N_COEF; k++) win[k] = m_hist[k-1];
            acc = 0;
            for (int k = 0; k < N_COEF; k++) acc += bank[k] * win[k];
            y = sat(acc >>> 7, -256, 255);
            d = (y >= 0) ? 128 : -128;
            e_y   = DATA_BW'(y);
            e_dec = (y >= 0);
            e_err = ERR_BW'(sat(d - y, -128, 127));
            e_x   = i_data;
            m_nv++;
            e_vld = 1'b1;
            e_lms = (m_nv >= LMS_AT);
            for (int k = N_COEF-2; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = win[0];
        end else begin
            e_vld = 1'b0;
            e_lms = 1'b0;
        end
        if (i_coef_load) begin
            for (int k = 0; k < N_COEF; k++) m_sh[k] = $signed(i_coefs[COEF_BW*k +: COEF_BW]);
            m_pend = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  32'(o_valid),  32'(e_vld));
        chk({tag, ".lms_en"}, 32'(o_lms_en), 32'(e_lms));
        chk({tag, ".y"},      32'(o_y),      32'(e_y));
        chk({tag, ".dec"},    32'(o_dec),    32'(e_dec));
        chk({tag, ".err"},    32'(o_err),    32'(e_err));
        chk({tag, ".x"},      32'(o_x),      32'(e_x));
    endtask

    task automatic step(input string tag, input logic [DATA_BW-1:0] d, input logic v,
                        input logic f, input logic l, input logic [CB-1:0] c);
        i_data = d; i_valid = v; i_flush = f; i_coef_load = l; i_coefs = c;
        @(posedge i_clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        int first;
        logic [CB-1:0] rc;
        logic [DATA_BW-1:0] xff;
        xff = 9'h0FF;

        i_rst_n = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Impulse through identity bank: appears at the centre tap.
        step("imp", 9'h040, 1, 0, 0, '0);
        for (int i = 2; i <= 9; i++) begin
            step("imp", 9'h000, 1, 0, 0, '0);
            if (i == 4) begin
                chk("imp_y4", 32'(o_y), 32'h040);
                chk("imp_err4", 32'(o_err), 32'h40);
            end
        end
        chk("zero_y", 32'(o_y), 32'h0);
        chk("zero_dec", 32'(o_dec), 32'h1);
        chk("zero_err", 32'(o_err), 32'h7F);

        // Saturation with all taps 0x0FF and constant 0x0FF input.
        step("ld_ff", 9'h000, 0, 0, 1, all_taps(9'h0FF));
        for (int i = 0; i < 8; i++) step("sat", xff, 1, 0, 0, '0);
        chk("sat_y", 32'(o_y), 32'h0FF);
        chk("sat_dec", 32'(o_dec), 32'h1);
        chk("sat_err", 32'(o_err), 32'h81);

        // Load coincident with a sample: old bank now, new bank next.
        step("ld_coinc", xff, 1, 0, 1, all_taps(9'h000));
        chk("ld_coinc_y", 32'(o_y), 32'h0FF);
        step("ld_next", xff, 1, 0, 0, '0);
        chk("ld_next_y", 32'(o_y), 32'h000);
        step("ld_a", 9'h000, 0, 0, 1, centre_tap(9'h080));
        step("ld_b", 9'h000, 0, 0, 1, centre_tap(9'h040));
        step("ld_win", xff, 1, 0, 0, '0);
        chk("ld_win_y", 32'(o_y), 32'h07F);
        // Load during a transfer keeps the new bank pending.
        step("ld_x", 9'h000, 0, 0, 1, centre_tap(9'h080));
        step("ld_xfer", xff, 1, 0, 1, all_taps(9'h000));
        chk("ld_xfer_y", 32'(o_y), 32'h0FF);
        step("ld_after", xff, 1, 0, 0, '0);
        chk("ld_after_y", 32'(o_y), 32'h000);

        // Random samples, loads and occasional flushes.
        for (int i = 0; i < 300; i++) begin
            rc = '0;
            for (int k = 0; k < N_COEF; k++) rc[COEF_BW*k +: COEF_BW] = COEF_BW'($urandom_range(0, 160) - 80);
            step("rand", DATA_BW'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 14) == 0), rc);
        end

        // Reach RUN, then flush (with a coincident sample) and time the re-enable.
        for (int i = 0; i < LMS_AT + 2; i++) step("run", DATA_BW'($urandom), 1, 0, 0, '0);
        chk("lms_run", 32'(o_lms_en), 32'h1);
        step("flush", 9'h055, 1, 1, 0, '0);
        chk("flush_vld", 32'(o_valid), 32'h0);
        first = 0;
        for (int i = 1; i <= 30; i++) begin
            step("refill", DATA_BW'($urandom), 1, 0, 0, '0);
            if (o_lms_en && first == 0) first = i;
        end
        chk("lms_first", 32'(first), 32'(LMS_AT));

        // Async reset with a load pending.
        step("pre_rst", 9'h0C3, 1, 0, 1, all_taps(9'h0FF));
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        #10;
        check_all("arst_hold");
        i_rst_n = 1'b1;
        step("imp2", 9'h040, 1, 0, 0, '0);
        for (int i = 2; i <= 5; i++) begin
            step("imp2", 9'h000, 1, 0, 0, '0);
            if (i == 4) chk("imp2_y4", 32'(o_y), 32'h040);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
